// File: rtl/operand_fifo_pkg.sv
// Shared constants, pointer-width helper and error tags for operand_fifo.
package operand_fifo_pkg;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;

    typedef enum logic [1:0] {ERR_NONE, ERR_OVF, ERR_UDF} fifo_err_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/operand_fifo_mem.sv
// Operand storage: one synchronous write port, one asynchronous read port, no reset.
module operand_fifo_mem
    import operand_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    localparam int AW    = ptr_w(DEPTH) - 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/operand_fifo.sv
// Synchronous operand FIFO with fill count, thresholds, sticky errors and flush.
// Define OPERAND_FIFO_FWFT_EN for first-word-fall-through reads.
module operand_fifo
    import operand_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_LVL = DEPTH - 1,
    parameter int AE_LVL = 1,
    localparam int PW    = ptr_w(DEPTH),
    localparam int AW    = PW - 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              pop_valid_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic [PW-1:0]     count_o,
    output logic              overflow_o,
    output logic              underflow_o
);
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [DATA_W-1:0] rdata;
    logic              push_acc, pop_acc;

    // Status is decoded from registered pointers only; the wrap bit disambiguates full/empty.
    assign count_o        = wr_ptr - rd_ptr;
    assign full_o         = (count_o == PW'(DEPTH));
    assign empty_o        = (count_o == '0);
    assign almost_full_o  = (count_o >= PW'(AF_LVL));
    assign almost_empty_o = (count_o <= PW'(AE_LVL));

    assign push_acc = push_i && !full_o && !clr_i;
    assign pop_acc  = pop_i && !empty_o && !clr_i;

    operand_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push_acc),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (push_data_i),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else if (clr_i) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + 1'b1;
            if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
            if (push_i && full_o) overflow_o  <= 1'b1;
            if (pop_i && empty_o) underflow_o <= 1'b1;
        end
    end

`ifdef OPERAND_FIFO_FWFT_EN
    assign pop_valid_o = !empty_o;
    assign pop_data_o  = empty_o ? '0 : rdata;
`else
    // A full FIFO drops the write, so the head read never races a write to the same slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_data_o  <= '0;
            pop_valid_o <= 1'b0;
        end else if (clr_i) begin
            pop_valid_o <= 1'b0;
        end else begin
            pop_valid_o <= pop_acc;
            if (pop_acc) pop_data_o <= rdata;
        end
    end
`endif
endmodule

// File: doc/operand_fifo.md
# operand_fifo

Parametrised synchronous FIFO that buffers operand words between the input staging logic and the MAC array in MAC_HW. It is the next generation of the single-width, fixed-depth MAC_HW FIFO and adds the following:
- a clock and an asynchronous active-high reset;
- a fill count and almost-full/almost-empty thresholds;
- sticky overflow/underflow error flags;
- a synchronous flush;
- a compile-time first-word-fall-through (FWFT) read mode.

## Interface
- DATA_W, 8, operand word width in bits (≥1)
- DEPTH, 4, number of entries; power of two, ≥2
- AF_LVL, DEPTH-1, almost_full_o threshold; 1 ≤ AF_LVL ≤ DEPTH
- AE_LVL, 1, almost_empty_o threshold; 0 ≤ AE_LVL < DEPTH
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- clr_i  in  1  synchronous flush: empties the FIFO and clears the sticky flags
- push_i  in  1  write request
- push_data_i  in  DATA_W  write data
- pop_i  in  1  read request
- pop_data_o  out  DATA_W  read data
- pop_valid_o  out  1  pop_data_o holds a valid popped word
- full_o  out  1  count == DEPTH
- empty_o  out  1  count == 0
- almost_full_o  out  1  count ≥ AF_LVL
- almost_empty_o  out  1  count ≤ AE_LVL
- count_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
- overflow_o  out  1  sticky: a push was dropped
- underflow_o  out  1  sticky: a pop was rejected

## Operation
- **Pointers.** wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits wide.
  - The low bits address the memory; the MSB is the wrap bit.
  - count_o = wr_ptr − rd_ptr, modulo 2^(AW+1).
- **Status outputs.** full_o, empty_o, almost_full_o, almost_empty_o and count_o are combinational decodes of the registered pointers only, never of the inputs.
- **Push acceptance.** A push is accepted when push_i && !full_o.
  - If full_o is set, the push is dropped and overflow_o is set, even if a pop is accepted in the same cycle.
- **Pop acceptance.** A pop is accepted when pop_i && !empty_o.
  - If empty_o is set, the pop is rejected and underflow_o is set, even if a push is accepted in the same cycle.
- **Push and pop together.** When both are accepted in one cycle, count_o is unchanged and both pointers advance.
- **Wrap-around.** Pointers increment modulo 2^(AW+1). There is no special case at DEPTH−1 → 0.
- **Flush (clr_i).**
  - Takes priority over push_i and pop_i in the same cycle; both are ignored.
  - Zeroes both pointers, overflow_o, underflow_o and pop_valid_o.
  - Leaves pop_data_o and the memory contents unchanged.
- **Error flags.** overflow_o and underflow_o stay set until rst or clr_i.
- **Reset.** rst is honoured asynchronously at any time, including mid-burst. All outputs return to their reset values immediately. The memory is not reset.
- **Reset values:**
  - pointers 0, count_o 0
  - empty_o 1, almost_empty_o 1
  - full_o 0, almost_full_o 0
  - pop_data_o 0, pop_valid_o 0
  - overflow_o 0, underflow_o 0

## Timing
- **Push.** A push accepted at edge k is visible in count_o and empty_o after edge k.
- **Standard mode (no macro).**
  - A pop accepted at edge k registers mem[rd_ptr] into pop_data_o at that edge.
  - pop_valid_o is 1 for exactly the cycle after edge k, giving a read latency of 1 cycle.
  - pop_data_o holds its last value when no pop is accepted.
- **Write-then-read.** A word pushed at edge k can be popped at edge k+1 at the earliest. There is no same-cycle bypass when empty.
- **Full-FIFO read/write.** When full, the head slot is both the slot being read and the next slot to be written. The read must return the old head word; the write is dropped in any case because the FIFO is full.

## Configuration
- **Macro: OPERAND_FIFO_FWFT_EN.**
- **Defined (FWFT mode):**
  - pop_data_o = mem[rd_ptr], combinationally, whenever !empty_o; 0 when empty.
  - pop_valid_o = !empty_o.
  - pop_i acts as an acknowledge: the next word appears after the accepting edge, giving a read latency of 0 cycles.
  - pop_data_o and pop_valid_o reset to 0 and 0.
- **Undefined:** the standard registered-read mode described above.

## Structure
- **Package operand_fifo_pkg:**
  - default DATA_W and DEPTH constants;
  - a ptr_w(depth) function returning $clog2(depth)+1;
  - an enum fifo_err_t {ERR_NONE, ERR_OVF, ERR_UDF} for bench scoreboarding.
- **Sub-module operand_fifo_mem:**
  - DATA_W×DEPTH storage with one synchronous write port (we, waddr, wdata);
  - one asynchronous read port (raddr, rdata);
  - no reset.
- **Top level:** pointers, flag decode, error flags and output register.

## Test plan
- **Reset:** assert rst mid-sequence → all outputs at their reset values immediately, without waiting for a clock edge; count_o=0, empty_o=1.
- **Fill and drain:** DEPTH=4; push 0x11,0x22,0x33,0x44 → full_o=1, count_o=4, almost_full_o=1 after the 3rd push. Then pop four times → 0x11,0x22,0x33,0x44 in order, pop_valid_o pulsing once per pop, empty_o=1 at the end.
- **Overflow:** push 0x55 while full → word dropped, overflow_o=1 and sticky, count_o stays 4. A subsequent pop returns 0x11, not 0x55.
- **Underflow:** pop when empty, together with a push of 0x66 → underflow_o=1, count_o=1, and the next pop returns 0x66.
- **Wrap and simultaneous push/pop:** hold count at 2 and push+pop every cycle for 10 cycles (pointers wrap twice) → count_o constant at 2 and the data order preserved.
- **Flush and FWFT:**
  - clr_i with push_i=1 at count 3 → count_o=0, flags cleared, the push ignored.
  - With OPERAND_FIFO_FWFT_EN defined: push 0xAA → pop_data_o=0xAA and pop_valid_o=1 before any pop.
